weight_stage_fifo: RTL and testbench



---
 rtl/weight_fifo_pkg.sv | 20 ++
 rtl/skew_line.sv | 43 ++++
 rtl/weight_stage_fifo.sv | 147 ++++++++++++++
 tb/tb_weight_stage_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_fifo_pkg.sv
// Shared types and helpers for the weight staging FIFO.
package weight_fifo_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } fifoState_t;

  // Width needed to hold a value in 0..depth.
  function automatic int countWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  // LSB position of a lane inside a packed multi-lane row bus.
  function automatic int laneLsb(input int lane, input int dataWidth);
    return lane * dataWidth;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Per-column delay line (data + valid) used to build the diagonal load wavefront.
// Only instantiated when WEIGHT_FIFO_SKEW_EN is defined.
module skew_line #(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  validIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut
);

  if (STAGES == 0) begin : gWire
    logic unusedClkRst;
    assign unusedClkRst = clk ^ reset;
    assign dataOut = validIn ? dataIn : '0;
    assign validOut = validIn;
  end else begin : gPipe
    logic [DATA_WIDTH-1:0] dataPipe [STAGES];
    logic [STAGES-1:0]     validPipe;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < STAGES; i++) dataPipe[i] <= '0;
        validPipe <= '0;
      end else begin
        dataPipe[0] <= dataIn;
        validPipe[0] <= validIn;
        for (int i = 1; i < STAGES; i++) begin
          dataPipe[i] <= dataPipe[i-1];
          validPipe[i] <= validPipe[i-1];
        end
      end
    end

    // Invalid lanes must read as zero on the array side.
    assign dataOut = validPipe[STAGES-1] ? dataPipe[STAGES-1] : '0;
    assign validOut = validPipe[STAGES-1];
  end

endmodule

// File: rtl/weight_stage_fifo.sv
// Weight staging buffer: accepts rows over valid/ready, drains oldest-first with lane reversal.
// Define WEIGHT_FIFO_SKEW_EN to delay output column c by c cycles (diagonal wavefront).
//
// state | meaning
// FILL  | accepting rows, count < DEPTH
// FULL  | DEPTH rows stored, input stalled
// DRAIN | emitting rows, then flushing skew tail
module weight_stage_fifo
  import weight_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_COLS = 4,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH*NUM_COLS-1:0] in_row,
  input  logic                           start_drain,
  output logic [DATA_WIDTH*NUM_COLS-1:0] out_row,
  output logic [NUM_COLS-1:0]            out_col_valid,
  output logic                           out_last,
  output logic [countWidth(DEPTH)-1:0]   count,
  output logic                           busy
);

  localparam int RW = DATA_WIDTH * NUM_COLS;
  localparam int CW = countWidth(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = countWidth(NUM_COLS);
`ifdef WEIGHT_FIFO_SKEW_EN
  localparam int TAIL = NUM_COLS - 1;
`else
  localparam int TAIL = 0;
`endif

  fifoState_t    state, stateNext;
  logic [RW-1:0] mem [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] countNext;
  logic [TW-1:0] tailCnt, tailNext;
  logic          doWrite, doEmit, lastEmit;
  logic [RW-1:0] rowRev;
  logic [RW-1:0] rowReg;
  logic          validReg, lastReg;

  always_comb begin
    stateNext = state;
    countNext = count;
    tailNext = tailCnt;
    in_ready = 1'b0;
    busy = 1'b0;
    doWrite = 1'b0;
    doEmit = 1'b0;
    lastEmit = 1'b0;
    unique case (state)
      FILL: begin
        in_ready = 1'b1;
        doWrite = in_valid;
        if (doWrite) countNext = count + 1'b1;
        // A row written alongside start_drain is part of this drain.
        if (start_drain && (count != '0 || doWrite)) begin
          stateNext = DRAIN;
          tailNext = TW'(TAIL);
        end else if (countNext == CW'(DEPTH)) begin
          stateNext = FULL;
        end
      end
      FULL: begin
        if (start_drain) begin
          stateNext = DRAIN;
          tailNext = TW'(TAIL);
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (count != '0) begin
          doEmit = 1'b1;
          lastEmit = (count == CW'(1));
          countNext = count - 1'b1;
          if (lastEmit && TAIL == 0) stateNext = FILL;
        end else begin
          // Down-count the skew tail so the last column finishes before FILL.
          tailNext = tailCnt - 1'b1;
          if (tailCnt == TW'(1)) stateNext = FILL;
        end
      end
      default: stateNext = FILL;
    endcase
  end

  always_comb begin
    rowRev = '0;
    for (int c = 0; c < NUM_COLS; c++)
      rowRev[laneLsb(c, DATA_WIDTH) +: DATA_WIDTH] =
        mem[rdPtr][laneLsb(NUM_COLS-1-c, DATA_WIDTH) +: DATA_WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
      count <= '0;
      tailCnt <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      rowReg <= '0;
      validReg <= 1'b0;
      lastReg <= 1'b0;
    end else begin
      state <= stateNext;
      count <= countNext;
      tailCnt <= tailNext;
      if (doWrite) wrPtr <= (wrPtr == PW'(DEPTH-1)) ? '0 : wrPtr + 1'b1;
      if (doEmit) rdPtr <= (rdPtr == PW'(DEPTH-1)) ? '0 : rdPtr + 1'b1;
      rowReg <= doEmit ? rowRev : '0;
      validReg <= doEmit;
      lastReg <= lastEmit;
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr] <= in_row;
  end

`ifdef WEIGHT_FIFO_SKEW_EN
  for (genvar c = 0; c < NUM_COLS; c++) begin : gSkew
    skew_line #(
      .DATA_WIDTH(DATA_WIDTH),
      .STAGES(c)
    ) uSkew (
      .clk(clk),
      .reset(reset),
      .dataIn(rowReg[laneLsb(c, DATA_WIDTH) +: DATA_WIDTH]),
      .validIn(validReg),
      .dataOut(out_row[laneLsb(c, DATA_WIDTH) +: DATA_WIDTH]),
      .validOut(out_col_valid[c])
    );
  end
  assign out_last = lastReg;
`else
  assign out_row = rowReg;
  assign out_col_valid = {NUM_COLS{validReg}};
  assign out_last = lastReg;
`endif

endmodule

// File: tb/tb_weight_stage_fifo.sv
// Scoreboard bench for weight_stage_fifo: per-column monitor checks drained lanes against queued rows.
module tb_weight_stage_fifo;
  localparam int DW = 8;
  localparam int NC = 4;
  localparam int DEPTH = 4;
`ifdef WEIGHT_FIFO_SKEW_EN
  localparam int TAIL = NC - 1;
  localparam logic [31:0] FIRST_MASK = 32'h0000_00FF;
`else
  localparam int TAIL = 0;
  localparam logic [31:0] FIRST_MASK = 32'hFFFF_FFFF;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        start_drain = 1'b0;
  logic [31:0] in_row = '0;
  logic        in_ready;
  logic [31:0] out_row;
  logic [3:0]  out_col_valid;
  logic        out_last;
  logic [2:0]  count;
  logic        busy;

  always #5 clk = ~clk;

  weight_stage_fifo #(.DATA_WIDTH(DW), .NUM_COLS(NC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_row(in_row),
    .start_drain(start_drain),
    .out_row(out_row),
    .out_col_valid(out_col_valid),
    .out_last(out_last),
    .count(count),
    .busy(busy)
  );

  typedef struct packed {
    logic [31:0] row;
    logic        last;
  } expRow_t;

  expRow_t     expQ[$];
  int          colIdx[NC];
  int          passCnt = 0;
  int          totalCnt = 0;
  logic [31:0] rows[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] revLanes(input logic [31:0] r);
    logic [31:0] o;
    for (int c = 0; c < NC; c++) o[c*DW +: DW] = r[(NC-1-c)*DW +: DW];
    return o;
  endfunction

  task automatic pushExp(input logic [31:0] r, input logic last);
    expRow_t e;
    e.row = revLanes(r);
    e.last = last;
    expQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fillRows(input string tag);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_row = rows[i];
      tick();
    end
    in_valid = 1'b0;
    check({tag, "_count_full"}, 32'(count), 32'd4);
    check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
  endtask

  task automatic runDrain(input string tag, input int nRows, input logic [31:0] firstOut,
                          input logic keepValid);
    int n;
    int firstAt;
    start_drain = 1'b1;
    tick();
    start_drain = 1'b0;
    if (!keepValid) in_valid = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    check({tag, "_no_early_row"}, 32'(out_col_valid), 32'd0);
    n = 0;
    firstAt = -1;
    while (busy && n < 50) begin
      n++;
      tick();
      if (firstAt < 0 && out_col_valid[0]) begin
        firstAt = n;
        check({tag, "_first_row"}, out_row, firstOut & FIRST_MASK);
      end
    end
    check({tag, "_latency"}, firstAt, 32'd1);
    check({tag, "_busy_cycles"}, n, nRows + TAIL);
    check({tag, "_count_zero"}, 32'(count), 32'd0);
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  task automatic settle(input string tag);
    repeat (NC + 2) tick();
    for (int c = 0; c < NC; c++)
      check($sformatf("%s_col%0d_consumed", tag, c), colIdx[c], expQ.size());
    expQ.delete();
    for (int c = 0; c < NC; c++) colIdx[c] = 0;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset && out_col_valid != '0) begin
        for (int c = 0; c < NC; c++) begin
          if (out_col_valid[c]) begin
            if (colIdx[c] < expQ.size()) begin
              check($sformatf("col%0d_row%0d", c, colIdx[c]),
                    32'(out_row[c*DW +: DW]), 32'(expQ[colIdx[c]].row[c*DW +: DW]));
              if (c == 0) check($sformatf("last_row%0d", colIdx[0]), 32'(out_last),
                                32'(expQ[colIdx[0]].last));
              colIdx[c]++;
            end else begin
              totalCnt++;
              $display("FAIL unexpected_col%0d: got row %0h expected none", c,
                       out_row[c*DW +: DW]);
            end
          end else begin
            check($sformatf("col%0d_idle_zero", c), 32'(out_row[c*DW +: DW]), 32'd0);
          end
        end
`ifndef WEIGHT_FIFO_SKEW_EN
        check("col_valid_equal", 32'(out_col_valid), 32'hF);
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    repeat (3) tick();
    check("rst_out_row", out_row, 32'd0);
    check("rst_col_valid", 32'(out_col_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    reset = 1'b0;
    tick();
    check("rst_ready", 32'(in_ready), 32'd1);

    // Fill to full, fifth row must not be stored, then full drain.
    rows = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hDDEE_FF00};
    fillRows("fill");
    in_valid = 1'b1;
    in_row = 32'hDEAD_BEEF;
    tick();
    tick();
    check("fifth_not_stored", 32'(count), 32'd4);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) pushExp(rows[i], i == 3);
    runDrain("full", 4, 32'h4433_2211, 1'b0);
    settle("full");

    // Partial: two rows, third written together with start_drain.
    in_valid = 1'b1;
    in_row = 32'h0A0B_0C0D;
    tick();
    in_row = 32'h1020_3040;
    tick();
    in_row = 32'hA5C3_5A3C;
    pushExp(32'h0A0B_0C0D, 1'b0);
    pushExp(32'h1020_3040, 1'b0);
    pushExp(32'hA5C3_5A3C, 1'b1);
    runDrain("partial", 3, 32'h0D0C_0B0A, 1'b0);
    settle("partial");

    // start_drain with nothing stored is ignored.
    start_drain = 1'b1;
    tick();
    start_drain = 1'b0;
    check("empty_no_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("empty_no_valid", 32'(out_col_valid), 32'd0);
    check("empty_count", 32'(count), 32'd0);

    // Backpressure: row held through FULL and DRAIN lands on first FILL cycle.
    rows = '{32'h0102_0304, 32'h1112_1314, 32'h2122_2324, 32'h3132_3334};
    fillRows("bp");
    in_valid = 1'b1;
    in_row = 32'hC0FF_EE11;
    tick();
    check("bp_hold_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) pushExp(rows[i], i == 3);
    runDrain("bp", 4, 32'h0403_0201, 1'b1);
    tick();
    check("bp_held_accepted", 32'(count), 32'd1);
    in_valid = 1'b0;
    settle("bp");
    pushExp(32'hC0FF_EE11, 1'b1);
    runDrain("bp_held", 1, 32'h11EE_FFC0, 1'b0);
    settle("bp_held");

    // Reset in the middle of a drain.
    rows = '{32'hC1C1_C1C1, 32'hC2C2_C2C2, 32'hC3C3_C3C3, 32'hC4C4_C4C4};
    fillRows("mid");
    for (int i = 0; i < 4; i++) pushExp(rows[i], i == 3);
    start_drain = 1'b1;
    tick();
    start_drain = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #1;
    check("mid_rows_before_reset", colIdx[0], 32'd2);
    reset = 1'b1;
    #1;
    check("mid_rst_out_row", out_row, 32'd0);
    check("mid_rst_col_valid", 32'(out_col_valid), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    expQ.delete();
    for (int c = 0; c < NC; c++) colIdx[c] = 0;
    tick();
    reset = 1'b0;
    tick();
    check("mid_ready_after", 32'(in_ready), 32'd1);
    check("mid_count_after", 32'(count), 32'd0);
    rows = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404};
    fillRows("post");
    for (int i = 0; i < 4; i++) pushExp(rows[i], i == 3);
    runDrain("post", 4, 32'h0101_0101, 1'b0);
    settle("post");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
